// File: rtl/sample_capture.sv
// Records a fixed-length window of an incoming sample stream into RAM, tracking
// the window's min/max, and exposes the stored window through a registered read port.
module sample_capture #(
    parameter int NBIT  = 12,
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            clear,
    input  logic            in_valid,
    input  logic [NBIT-1:0] in_sample,
    output logic [AW:0]     count,
    output logic [NBIT-1:0] smin,
    output logic [NBIT-1:0] smax,
    output logic            over,
    input  logic            rd_en,
    input  logic [AW-1:0]   rd_addr,
    output logic [NBIT-1:0] rd_data,
    output logic            rd_valid
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [AW:0]     count_q, count_d;
    logic [NBIT-1:0] smin_q, smin_d;
    logic [NBIT-1:0] smax_q, smax_d;
    logic            over_q, over_d;
    logic [NBIT-1:0] rd_data_q, rd_data_d;
    logic            rd_valid_q, rd_valid_d;
    logic            wr_en;

    logic [NBIT-1:0] mem [DEPTH];

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        smin_d     = smin_q;
        smax_d     = smax_q;
        over_d     = (state_q == DONE);
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        wr_en      = 1'b0;

        if (clear) begin
            state_d = IDLE;
            over_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = CAPTURE;
                        count_d = '0;
                    end
                end
                CAPTURE: begin
                    if (in_valid) begin
                        wr_en   = 1'b1;
                        count_d = count_q + (AW+1)'(1);
                        // The first sample of a window seeds both extremes.
                        if (count_q == '0) begin
                            smin_d = in_sample;
                            smax_d = in_sample;
                        end else begin
                            if (in_sample < smin_q) smin_d = in_sample;
                            if (in_sample > smax_q) smax_d = in_sample;
                        end
                        if (count_d == DEPTH_W) state_d = DONE;
                    end
                end
                DONE: begin
                    if (rd_en) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = ({1'b0, rd_addr} < DEPTH_W) ? mem[rd_addr] : '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            smin_q     <= '0;
            smax_q     <= '0;
            over_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            smin_q     <= smin_d;
            smax_q     <= smax_d;
            over_q     <= over_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Sample storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[count_q[AW-1:0]] <= in_sample;
    end

    assign count    = count_q;
    assign smin     = smin_q;
    assign smax     = smax_q;
    assign over     = over_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_sample_capture.sv
// Randomised bench for sample_capture: a queue-based window model predicts count,
// min/max, over and readback data; outputs are sampled on the falling clock edge.
module tb_sample_capture;

    localparam int NBIT  = 12;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic            clear = 1'b0;
    logic            in_valid = 1'b0;
    logic [NBIT-1:0] in_sample = '0;
    logic            rd_en = 1'b0;
    logic [AW-1:0]   rd_addr = '0;
    logic [AW:0]     count;
    logic [NBIT-1:0] smin;
    logic [NBIT-1:0] smax;
    logic            over;
    logic [NBIT-1:0] rd_data;
    logic            rd_valid;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the window is simply the list of accepted samples.
    logic [NBIT-1:0] win[$];
    bit              m_capturing = 0;

    sample_capture #(.NBIT(NBIT), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .in_valid(in_valid), .in_sample(in_sample),
        .count(count), .smin(smin), .smax(smax), .over(over),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
    );

    always #10 clk = ~clk;

    function automatic logic [NBIT-1:0] win_min();
        logic [NBIT-1:0] m = win[0];
        foreach (win[i]) if (win[i] < m) m = win[i];
        return m;
    endfunction

    function automatic logic [NBIT-1:0] win_max();
        logic [NBIT-1:0] m = win[0];
        foreach (win[i]) if (win[i] > m) m = win[i];
        return m;
    endfunction

    task automatic drive_cycle(input logic v, input logic [NBIT-1:0] d);
        in_valid  = v;
        in_sample = d;
        @(negedge clk);
        if (m_capturing && v) begin
            win.push_back(d);
            if (win.size() == DEPTH) m_capturing = 0;
        end
        in_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_capturing = 0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        win.delete();
        m_capturing = 1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        @(negedge clk);
        n_checks += 6;
        if (count !== 0)    begin n_fail++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        if (smin !== 0)     begin n_fail++; $display("[TB] FAIL reset_smin: got %0d expected 0", smin); end
        if (smax !== 0)     begin n_fail++; $display("[TB] FAIL reset_smax: got %0d expected 0", smax); end
        if (over !== 0)     begin n_fail++; $display("[TB] FAIL reset_over: got %0b expected 0", over); end
        if (rd_data !== 0)  begin n_fail++; $display("[TB] FAIL reset_rd_data: got %0d expected 0", rd_data); end
        if (rd_valid !== 0) begin n_fail++; $display("[TB] FAIL reset_rd_valid: got %0b expected 0", rd_valid); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_capture();
        logic [NBIT-1:0] seq [DEPTH] = '{100, 250, 75, 4095, 0, 300, 300, 12};
        do_start();
        n_checks++;
        if (count !== 0) begin n_fail++; $display("[TB] FAIL cap_start_count: got %0d expected 0", count); end
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH-1) rd_en = 1'b1;
            rd_addr = '0;
            drive_cycle(1'b1, seq[i]);
            n_checks++;
            if (count !== win.size()) begin n_fail++; $display("[TB] FAIL cap_count: got %0d expected %0d", count, win.size()); end
        end
        rd_en = 1'b0;
        n_checks++;
        if (over !== 1'b0) begin n_fail++; $display("[TB] FAIL cap_over_early: got %0b expected 0", over); end
        @(negedge clk);
        n_checks += 5;
        if (over !== 1'b1)     begin n_fail++; $display("[TB] FAIL cap_over: got %0b expected 1", over); end
        if (rd_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL cap_last_write_read: got %0b expected 0", rd_valid); end
        if (count !== DEPTH)   begin n_fail++; $display("[TB] FAIL cap_final_count: got %0d expected %0d", count, DEPTH); end
        if (smin !== win_min()) begin n_fail++; $display("[TB] FAIL cap_smin: got %0d expected %0d", smin, win_min()); end
        if (smax !== win_max()) begin n_fail++; $display("[TB] FAIL cap_smax: got %0d expected %0d", smax, win_max()); end
    endtask

    task automatic test_readback();
        rd_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = AW'(i);
            @(negedge clk);
            n_checks += 2;
            if (rd_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL rb_valid[%0d]: got %0b expected 1", i, rd_valid); end
            if (rd_data !== win[i]) begin n_fail++; $display("[TB] FAIL rb_data[%0d]: got %0d expected %0d", i, rd_data, win[i]); end
        end
        rd_en = 1'b0;
        @(negedge clk);
        n_checks += 2;
        if (rd_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rb_idle_valid: got %0b expected 0", rd_valid); end
        if (rd_data !== win[DEPTH-1]) begin n_fail++; $display("[TB] FAIL rb_hold: got %0d expected %0d", rd_data, win[DEPTH-1]); end
        do_clear();
        rd_en = 1'b1;
        rd_addr = 3'd2;
        @(negedge clk);
        rd_en = 1'b0;
        n_checks += 3;
        if (rd_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rb_in_idle_valid: got %0b expected 0", rd_valid); end
        if (rd_data !== win[DEPTH-1]) begin n_fail++; $display("[TB] FAIL rb_in_idle_hold: got %0d expected %0d", rd_data, win[DEPTH-1]); end
        if (over !== 1'b0) begin n_fail++; $display("[TB] FAIL rb_clear_over: got %0b expected 0", over); end
    endtask

    task automatic test_gaps();
        bit pat [5] = '{1, 0, 1, 1, 0};
        int k = 0;
        do_start();
        while (m_capturing && k < 100) begin
            drive_cycle((k < 5) ? pat[k] : 1'($urandom_range(0, 1)), NBIT'($urandom_range(0, 4095)));
            k++;
            n_checks++;
            if (count !== win.size()) begin n_fail++; $display("[TB] FAIL gap_count: got %0d expected %0d", count, win.size()); end
        end
        n_checks++;
        if (m_capturing) begin n_fail++; $display("[TB] FAIL gap_timeout: got %0d samples expected %0d", win.size(), DEPTH); end
        @(negedge clk);
        n_checks += 3;
        if (over !== 1'b1)      begin n_fail++; $display("[TB] FAIL gap_over: got %0b expected 1", over); end
        if (smin !== win_min()) begin n_fail++; $display("[TB] FAIL gap_smin: got %0d expected %0d", smin, win_min()); end
        if (smax !== win_max()) begin n_fail++; $display("[TB] FAIL gap_smax: got %0d expected %0d", smax, win_max()); end
        rd_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = AW'(i);
            @(negedge clk);
            n_checks++;
            if (rd_data !== win[i]) begin n_fail++; $display("[TB] FAIL gap_rb[%0d]: got %0d expected %0d", i, rd_data, win[i]); end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_clear_restart();
        do_clear();
        do_start();
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, NBIT'($urandom_range(100, 4095)));
        do_clear();
        n_checks += 3;
        if (count !== 3)        begin n_fail++; $display("[TB] FAIL clr_count_held: got %0d expected 3", count); end
        if (over !== 1'b0)      begin n_fail++; $display("[TB] FAIL clr_over: got %0b expected 0", over); end
        if (smin !== win_min()) begin n_fail++; $display("[TB] FAIL clr_smin_held: got %0d expected %0d", smin, win_min()); end
        start = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        start = 1'b0;
        clear = 1'b0;
        n_checks++;
        if (count !== 3) begin n_fail++; $display("[TB] FAIL clr_start_same_cycle: got %0d expected 3", count); end
        do_start();
        n_checks++;
        if (count !== 0) begin n_fail++; $display("[TB] FAIL clr_restart_count: got %0d expected 0", count); end
        for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, 12'd7);
        @(negedge clk);
        n_checks += 4;
        if (count !== DEPTH) begin n_fail++; $display("[TB] FAIL clr_final_count: got %0d expected %0d", count, DEPTH); end
        if (smin !== 7)      begin n_fail++; $display("[TB] FAIL clr_smin: got %0d expected 7", smin); end
        if (smax !== 7)      begin n_fail++; $display("[TB] FAIL clr_smax: got %0d expected 7", smax); end
        if (over !== 1'b1)   begin n_fail++; $display("[TB] FAIL clr_over_done: got %0b expected 1", over); end
    endtask

    task automatic test_after_done();
        start = 1'b1;
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 12'd999);
        start = 1'b0;
        n_checks += 3;
        if (count !== DEPTH)    begin n_fail++; $display("[TB] FAIL done_count: got %0d expected %0d", count, DEPTH); end
        if (smax !== win_max()) begin n_fail++; $display("[TB] FAIL done_smax: got %0d expected %0d", smax, win_max()); end
        if (over !== 1'b1)      begin n_fail++; $display("[TB] FAIL done_over: got %0b expected 1", over); end
        rd_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = AW'(i);
            @(negedge clk);
            n_checks++;
            if (rd_data !== win[i]) begin n_fail++; $display("[TB] FAIL done_rb[%0d]: got %0d expected %0d", i, rd_data, win[i]); end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic [NBIT-1:0] s;
        do_clear();
        do_start();
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, NBIT'($urandom_range(1, 4095)));
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        win.delete();
        m_capturing = 0;
        n_checks += 6;
        if (count !== 0)    begin n_fail++; $display("[TB] FAIL mr_count: got %0d expected 0", count); end
        if (smin !== 0)     begin n_fail++; $display("[TB] FAIL mr_smin: got %0d expected 0", smin); end
        if (smax !== 0)     begin n_fail++; $display("[TB] FAIL mr_smax: got %0d expected 0", smax); end
        if (over !== 0)     begin n_fail++; $display("[TB] FAIL mr_over: got %0b expected 0", over); end
        if (rd_data !== 0)  begin n_fail++; $display("[TB] FAIL mr_rd_data: got %0d expected 0", rd_data); end
        if (rd_valid !== 0) begin n_fail++; $display("[TB] FAIL mr_rd_valid: got %0b expected 0", rd_valid); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_start();
        n_checks++;
        if (count !== 0) begin n_fail++; $display("[TB] FAIL mr_restart_count: got %0d expected 0", count); end
        s = NBIT'($urandom_range(0, 4095));
        drive_cycle(1'b1, s);
        n_checks += 3;
        if (count !== 1) begin n_fail++; $display("[TB] FAIL mr_first_count: got %0d expected 1", count); end
        if (smin !== s)  begin n_fail++; $display("[TB] FAIL mr_first_smin: got %0d expected %0d", smin, s); end
        if (smax !== s)  begin n_fail++; $display("[TB] FAIL mr_first_smax: got %0d expected %0d", smax, s); end
        for (int i = 1; i < DEPTH; i++) drive_cycle(1'b1, NBIT'($urandom_range(0, 4095)));
        @(negedge clk);
        n_checks += 3;
        if (over !== 1'b1)      begin n_fail++; $display("[TB] FAIL mr_over_done: got %0b expected 1", over); end
        if (smin !== win_min()) begin n_fail++; $display("[TB] FAIL mr_smin_done: got %0d expected %0d", smin, win_min()); end
        if (smax !== win_max()) begin n_fail++; $display("[TB] FAIL mr_smax_done: got %0d expected %0d", smax, win_max()); end
    endtask

    initial begin
        $display("[TB] starting sample_capture bench");
        test_reset();
        test_capture();
        test_readback();
        test_gaps();
        test_clear_restart();
        test_after_done();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sample_capture.md
Name: sample_capture

Overview:
- Sink-side counterpart to the sample-streaming ROM. It accepts an NBIT sample stream (one sample per valid cycle) and records a fixed-length window into internal RAM.
- It tracks the running minimum and maximum of the window and asserts over when the window is full.
- After capture, the stored window can be read back through a registered read port. The heart-rate detection stage uses that port, and benches use it for self-checking.

Parameters:
- NBIT, 12, sample width in bits (unsigned).
- DEPTH, 1024, number of samples per capture window; ≥2.
- AW, 10, address width; must satisfy 2^AW ≥ DEPTH.

Ports:
- clk  in  1  system clock, 50 MHz nominal, rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  level; begins capture when sampled high in IDLE.
- clear  in  1  synchronous; returns the block to IDLE from any state.
- in_valid  in  1  sample qualifier.
- in_sample  in  NBIT  incoming sample.
- count  out  AW+1  number of samples stored in the current window.
- smin  out  NBIT  minimum stored sample.
- smax  out  NBIT  maximum stored sample.
- over  out  1  high while in DONE.
- rd_en  in  1  read request.
- rd_addr  in  AW  read address.
- rd_data  out  NBIT  read data.
- rd_valid  out  1  qualifies rd_data.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, count=0, smin=0, smax=0, over=0, rd_data=0, rd_valid=0.
  - RAM contents are not reset.
- States:
  - IDLE: count, smin and smax hold their previous values. start=1 → CAPTURE on the next edge; count is cleared to 0 on that edge.
  - CAPTURE: on each edge with in_valid=1, mem[count] ← in_sample and count ← count+1.
    - First sample of the window (count==0): smin and smax both load in_sample.
    - Later samples: smin ← min(smin, in_sample); smax ← max(smax, in_sample), unsigned compare.
    - When the write brings count to DEPTH, state → DONE on the same edge. over goes high the following cycle, i.e. over is registered from state==DONE.
    - in_valid=0 cycles are gaps: nothing changes.
  - DONE: over=1. in_valid and start are ignored. count, smin and smax are held.
- clear=1 has priority over everything:
  - next state = IDLE, over=0, rd_valid=0.
  - count, smin and smax are held (they are not cleared) until the next start.
  - clear during CAPTURE abandons the window: the partial count remains visible, and no further writes occur.
- start held high after DONE has no effect. A new window requires clear, then start.
- Read port:
  - Read latency is 1 cycle. An rd_en sampled high in DONE gives rd_valid=1 and rd_data=mem[rd_addr] on the next cycle.
  - rd_addr ≥ DEPTH gives rd_data=0 with rd_valid=1.
  - rd_en outside DONE gives rd_valid=0; rd_data holds its last value.
  - Back-to-back reads are supported, one per cycle.
- Simultaneous events:
  - start and clear together in IDLE: clear wins, state stays IDLE.
  - Last write and rd_en on the same edge: the rd_en is ignored, because state was not yet DONE.
- Mid-operation reset: asynchronously forces the reset values above. Any RAM write on that edge is not guaranteed.

Test Plan:
- Bench parameters for all scenarios: DEPTH=8, NBIT=12, AW=3.
- Scenario 1: reset, then start, then 8 consecutive valid samples 100,250,75,4095,0,300,300,12 → over rises 1 cycle after the 8th write; count=8, smin=0, smax=4095.
- Scenario 2: in DONE, rd_en with rd_addr=0..7 on back-to-back cycles → rd_valid=1 from the next cycle; rd_data = the scenario 1 sequence in order. rd_addr=7 followed by a rogue rd_addr beyond range is not possible at AW=3, so instead test rd_en in IDLE → rd_valid=0.
- Scenario 3: valid pattern 1,0,1,1,0,… with samples 5,9,… → only valid cycles are stored; count increments only on valid; over appears after the 8th valid sample regardless of gaps.
- Scenario 4: clear asserted after 3 samples, then start, then 8 samples of 7 → count restarts from 0; smin=smax=7; the earlier smin/smax are not retained.
- Scenario 5: extra in_valid samples of 999 after over=1 → RAM unchanged on readback; count stays 8; smax unchanged.
- Scenario 6: rst driven low mid-capture, asynchronously between clock edges → outputs reach reset values immediately; start after release begins a fresh window with count 0.
